// File: rtl/alu_opstack.sv
// Operand stack that feeds an external combinational ALU. Push, pop and ALU
// commands are sequenced by an IDLE/EXEC/DONE FSM. Rejection reporting on err
// is enabled by defining OPSTACK_ERR_EN.
module alu_opstack #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_type,
  input  logic [3:0]                 cmd_op,
  input  logic [31:0]                cmd_data,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [3:0]                 alu_op,
  input  logic [31:0]                alu_result,
  output logic [31:0]                top,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);

`ifdef OPSTACK_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_POP  = 2'b01;
  localparam logic [1:0] CMD_ALU  = 2'b10;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_REM = 4'b0100;
  localparam logic [3:0] OP_NEG = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_AND = 4'b1111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state, state_nx;
  logic [31:0]     mem [DEPTH];
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   cnt_m1, cnt_m2;
  logic [AW-1:0]   idx0, idx1, idx2;
  logic            accept;
  logic            op_legal, op_unary, exec_unary, div_zero;
  logic            ld_alu;
  logic [31:0]     opa, opb;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [31:0]     wr_data;
  logic            err_q, err_nx;

  assign cnt_m1 = cnt - CNT_ONE;
  assign cnt_m2 = cnt - CNT_TWO;
  assign idx0   = cnt[AW-1:0];
  assign idx1   = cnt_m1[AW-1:0];
  assign idx2   = cnt_m2[AW-1:0];

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign top       = (cnt == '0) ? '0 : mem[idx1];
  assign depth     = cnt;
  assign done      = (state == DONE);
  // err_q is only ever set on the transition into DONE, so it already is a pulse
  assign err       = ERR_EN & err_q;

  always_comb begin
    op_legal = 1'b0;
    case (cmd_op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM, OP_NEG,
      OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  assign op_unary   = (cmd_op == OP_NEG);
  assign exec_unary = (alu_op == OP_NEG);
  assign div_zero   = ERR_EN && ((alu_op == OP_DIV) || (alu_op == OP_REM))
                      && (alu_b[15:0] == 16'h0000);
  assign opa        = op_unary ? top : mem[idx2];
  assign opb        = op_unary ? '0 : top;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ld_alu   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_data  = '0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = DONE;
          case (cmd_type)
            CMD_PUSH: begin
              if (cnt == CNT_FULL) begin
                err_nx = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wr_idx  = idx0;
                wr_data = cmd_data;
                cnt_nx  = cnt + CNT_ONE;
              end
            end
            CMD_POP: begin
              if (cnt == '0) err_nx = 1'b1;
              else           cnt_nx = cnt_m1;
            end
            CMD_ALU: begin
              if (!op_legal || (op_unary ? (cnt < CNT_ONE) : (cnt < CNT_TWO))) begin
                err_nx = 1'b1;
              end else begin
                ld_alu   = 1'b1;
                state_nx = EXEC;
              end
            end
            default: err_nx = 1'b1;
          endcase
        end
      end
      EXEC: begin
        state_nx = DONE;
        if (div_zero) begin
          err_nx = 1'b1;
        end else if (exec_unary) begin
          wr_en   = 1'b1;
          wr_idx  = idx1;
          wr_data = alu_result;
        end else begin
          // Binary result lands on the lower operand, then the stack shrinks
          wr_en   = 1'b1;
          wr_idx  = idx2;
          wr_data = alu_result;
          cnt_nx  = cnt_m1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
      if (ld_alu) begin
        alu_a  <= opa;
        alu_b  <= opb;
        alu_op <= cmd_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_alu_opstack.sv
// Self-checking bench for alu_opstack: directed scenarios plus randomized
// commands compared against a queue-based stack model and a behavioural ALU.
module tb_alu_opstack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = $clog2(DEPTH) + 1;

`ifdef OPSTACK_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [3:0]    cmd_op;
  logic [31:0]   cmd_data;
  logic [31:0]   alu_a, alu_b;
  logic [3:0]    alu_op;
  logic [31:0]   alu_result;
  logic [31:0]   top;
  logic [DW-1:0] depth;
  logic          done, err;

  always #5 clk = ~clk;

  alu_opstack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .top(top), .depth(depth), .done(done), .err(err)
  );

  // External ALU; neg is the bitwise complement
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a * b;
      4'b0011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b0100: return (b == 0) ? a : a % b;
      4'b0101: return ~a;
      4'b1100: return a << b[4:0];
      4'b1101: return a >> b[4:0];
      4'b1111: return a & b;
      4'b1000: return a | b;
      4'b1001: return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  int total = 0;
  int bad   = 0;

  logic [31:0] q[$];
  int          e_lat;
  bit          e_err, e_alu;
  logic [31:0] e_a, e_b;

  int          o_lat;
  logic        o_err, o_ready;
  logic [31:0] o_a, o_b, o_top;
  logic [3:0]  o_op;
  logic [DW-1:0] o_depth;

  function automatic logic [31:0] m_top();
    return (q.size() == 0) ? 32'h0 : q[q.size()-1];
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13, 4'd15};
  endfunction

  task automatic model_cmd(input logic [1:0] t, input logic [3:0] op, input logic [31:0] d);
    int n = q.size();
    bit rej = 0;
    logic [31:0] a, b;
    e_lat = 1; e_err = 0; e_alu = 0; e_a = 0; e_b = 0;
    case (t)
      2'b00: if (n == DEPTH) rej = 1; else q.push_back(d);
      2'b01: if (n == 0) rej = 1; else void'(q.pop_back());
      2'b10: begin
        if (!legal_op(op) || ((op == 4'd5) ? (n < 1) : (n < 2))) rej = 1;
        else begin
          e_alu = 1; e_lat = 2;
          if (op == 4'd5) begin
            a = q[n-1]; b = 0;
            q[n-1] = alu_fn(op, a, b);
          end else begin
            a = q[n-2]; b = q[n-1];
            if (ERR_ON && (op == 4'd3 || op == 4'd4) && b[15:0] == 16'h0) e_err = 1;
            else begin
              void'(q.pop_back());
              q[n-2] = alu_fn(op, a, b);
            end
          end
          e_a = a; e_b = b;
        end
      end
      default: rej = 1;
    endcase
    if (rej && ERR_ON) e_err = 1;
  endtask

  // Drives one command and records what the DUT showed; no judgement here
  task automatic do_cmd(input logic [1:0] t, input logic [3:0] op, input logic [31:0] d, input bit hold);
    @(negedge clk);
    o_ready = cmd_ready;
    cmd_valid = 1'b1; cmd_type = t; cmd_op = op; cmd_data = d;
    @(posedge clk);
    o_lat = 0; o_err = 0; o_a = 0; o_b = 0; o_op = 0; o_top = 0; o_depth = 0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!hold) cmd_valid = 1'b0;
      if (done) begin
        o_lat = i; o_err = err; o_top = top; o_depth = depth;
        cmd_valid = 1'b0;
        break;
      end
      o_a = alu_a; o_b = alu_b; o_op = alu_op;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_type = 0; cmd_op = 0; cmd_data = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1 || depth !== '0 || top !== 32'h0 || done !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl ready=%b depth=%0d top=%h done=%b err=%b want 1/0/0/0/0",
               cmd_ready, depth, top, done, err);
    end
    total++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 4'h0) begin
      bad++;
      $display("FAIL reset_alu a=%h b=%h op=%h want all zero", alu_a, alu_b, alu_op);
    end
    q.delete();
  endtask

  task automatic test_add();
    apply_reset();
    model_cmd(2'b00, 0, 7);  do_cmd(2'b00, 0, 7, 0);
    model_cmd(2'b00, 0, 5);  do_cmd(2'b00, 0, 5, 0);
    total++;
    if (o_lat !== 1 || o_depth !== DW'(2) || o_top !== 32'd5) begin
      bad++;
      $display("FAIL push_5 lat=%0d depth=%0d top=%0d want 1/2/5", o_lat, o_depth, o_top);
    end
    model_cmd(2'b10, 4'b0000, 0); do_cmd(2'b10, 4'b0000, 0, 0);
    total++;
    if (o_a !== 32'd7 || o_b !== 32'd5 || o_op !== 4'b0000) begin
      bad++;
      $display("FAIL add_operands a=%0d b=%0d op=%h want 7/5/0", o_a, o_b, o_op);
    end
    total++;
    if (o_lat !== 2 || o_err !== 1'b0 || o_top !== 32'd12 || o_depth !== DW'(1)) begin
      bad++;
      $display("FAIL add_result lat=%0d err=%b top=%0d depth=%0d want 2/0/12/1", o_lat, o_err, o_top, o_depth);
    end
  endtask

  task automatic test_sub_neg();
    apply_reset();
    model_cmd(2'b00, 0, 20); do_cmd(2'b00, 0, 20, 0);
    model_cmd(2'b00, 0, 3);  do_cmd(2'b00, 0, 3, 0);
    model_cmd(2'b10, 4'b0001, 0); do_cmd(2'b10, 4'b0001, 0, 0);
    total++;
    if (o_top !== 32'd17 || o_depth !== DW'(1)) begin
      bad++;
      $display("FAIL sub_result top=%0d depth=%0d want 17/1", o_top, o_depth);
    end
    model_cmd(2'b10, 4'b0101, 0); do_cmd(2'b10, 4'b0101, 0, 0);
    total++;
    if (o_a !== 32'd17 || o_b !== 32'h0 || o_lat !== 2) begin
      bad++;
      $display("FAIL neg_operands a=%0d b=%h lat=%0d want 17/0/2", o_a, o_b, o_lat);
    end
    total++;
    if (o_top !== 32'hFFFF_FFEE || o_depth !== DW'(1)) begin
      bad++;
      $display("FAIL neg_result top=%h depth=%0d want ffffffee/1", o_top, o_depth);
    end
  endtask

  task automatic test_full_empty();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_cmd(2'b00, 0, d); do_cmd(2'b00, 0, d, 0);
      total++;
      if (o_top !== d || o_depth !== DW'(i + 1)) begin
        bad++;
        $display("FAIL fill[%0d] top=%h depth=%0d want %h/%0d", i, o_top, o_depth, d, i + 1);
      end
    end
    model_cmd(2'b00, 0, 32'hDEAD_BEEF); do_cmd(2'b00, 0, 32'hDEAD_BEEF, 0);
    total++;
    if (o_lat !== 1 || o_err !== ERR_ON || o_depth !== DW'(DEPTH) || o_top !== m_top()) begin
      bad++;
      $display("FAIL push_full lat=%0d err=%b depth=%0d top=%h want 1/%b/%0d/%h",
               o_lat, o_err, o_depth, o_top, ERR_ON, DEPTH, m_top());
    end
    for (int i = 0; i < DEPTH; i++) begin
      model_cmd(2'b01, 0, 0); do_cmd(2'b01, 0, 0, 0);
    end
    total++;
    if (o_top !== 32'h0 || o_depth !== '0 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL drain top=%h depth=%0d err=%b want 0/0/0", o_top, o_depth, o_err);
    end
    model_cmd(2'b01, 0, 0); do_cmd(2'b01, 0, 0, 0);
    total++;
    if (o_lat !== 1 || o_err !== ERR_ON || o_depth !== '0 || o_top !== 32'h0) begin
      bad++;
      $display("FAIL pop_empty lat=%0d err=%b depth=%0d top=%h want 1/%b/0/0", o_lat, o_err, o_depth, o_top, ERR_ON);
    end
  endtask

  task automatic test_div_zero();
    apply_reset();
    model_cmd(2'b00, 0, 9); do_cmd(2'b00, 0, 9, 0);
    model_cmd(2'b00, 0, 0); do_cmd(2'b00, 0, 0, 0);
    model_cmd(2'b10, 4'b0011, 0); do_cmd(2'b10, 4'b0011, 0, 0);
    total++;
    if (o_lat !== 2 || o_err !== ERR_ON) begin
      bad++;
      $display("FAIL div0_done lat=%0d err=%b want 2/%b", o_lat, o_err, ERR_ON);
    end
    total++;
    if (o_depth !== DW'(ERR_ON ? 2 : 1) || o_top !== m_top()) begin
      bad++;
      $display("FAIL div0_stack depth=%0d top=%h want %0d/%h", o_depth, o_top, ERR_ON ? 2 : 1, m_top());
    end
  endtask

  task automatic test_rst_exec();
    apply_reset();
    model_cmd(2'b00, 0, 1); do_cmd(2'b00, 0, 1, 0);
    model_cmd(2'b00, 0, 2); do_cmd(2'b00, 0, 2, 0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_type = 2'b10; cmd_op = 4'b1100;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (depth !== '0 || top !== 32'h0 || alu_a !== 32'h0 || done !== 1'b0) begin
      bad++;
      $display("FAIL rst_in_exec depth=%0d top=%h alu_a=%h done=%b want 0/0/0/0", depth, top, alu_a, done);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_no_done done=%b ready=%b want 0/1", done, cmd_ready);
    end
    model_cmd(2'b00, 0, 4); do_cmd(2'b00, 0, 4, 0);
    total++;
    if (o_top !== 32'd4 || o_depth !== DW'(1)) begin
      bad++;
      $display("FAIL push_after_rst top=%0d depth=%0d want 4/1", o_top, o_depth);
    end
  endtask

  task automatic test_reject_hold();
    apply_reset();
    model_cmd(2'b00, 0, 11); do_cmd(2'b00, 0, 11, 0);
    model_cmd(2'b00, 0, 6);  do_cmd(2'b00, 0, 6, 0);
    model_cmd(2'b11, 0, 99); do_cmd(2'b11, 0, 99, 0);
    total++;
    if (o_lat !== 1 || o_err !== ERR_ON || o_top !== 32'd6 || o_depth !== DW'(2)) begin
      bad++;
      $display("FAIL type11 lat=%0d err=%b top=%0d depth=%0d want 1/%b/6/2", o_lat, o_err, o_top, o_depth, ERR_ON);
    end
    model_cmd(2'b10, 4'b0110, 0); do_cmd(2'b10, 4'b0110, 0, 0);
    total++;
    if (o_lat !== 1 || o_err !== ERR_ON || o_top !== 32'd6 || o_depth !== DW'(2)) begin
      bad++;
      $display("FAIL op0110 lat=%0d err=%b top=%0d depth=%0d want 1/%b/6/2", o_lat, o_err, o_top, o_depth, ERR_ON);
    end
    // Held valid across EXEC/DONE must yield exactly one multiply
    model_cmd(2'b10, 4'b0010, 0); do_cmd(2'b10, 4'b0010, 0, 1);
    @(negedge clk);
    total++;
    if (o_lat !== 2 || top !== 32'd66 || depth !== DW'(1) || done !== 1'b0) begin
      bad++;
      $display("FAIL hold_valid lat=%0d top=%0d depth=%0d done=%b want 2/66/1/0", o_lat, top, depth, done);
    end
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [3:0] op;
    logic [31:0] d;
    int r;
    logic [3:0] legal_list [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13, 4'd15};
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      t = (r < 40) ? 2'b00 : (r < 55) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      op = ($urandom_range(0, 9) < 8) ? legal_list[$urandom_range(0, 10)] : 4'($urandom);
      r = $urandom_range(0, 9);
      d = (r == 0) ? 32'h0 : (r == 1) ? 32'h0001_0000 : (r == 2) ? 32'($urandom_range(1, 40)) : $urandom;
      model_cmd(t, op, d);
      do_cmd(t, op, d, 0);
      total++;
      if (o_ready !== 1'b1 || o_lat !== e_lat || o_err !== e_err) begin
        bad++;
        $display("FAIL rand_done[%0d] t=%0d op=%h ready=%b lat=%0d err=%b want 1/%0d/%b",
                 n, t, op, o_ready, o_lat, o_err, e_lat, e_err);
      end
      total++;
      if (o_top !== m_top() || o_depth !== DW'(q.size())) begin
        bad++;
        $display("FAIL rand_stack[%0d] t=%0d op=%h top=%h depth=%0d want %h/%0d",
                 n, t, op, o_top, o_depth, m_top(), q.size());
      end
      if (e_alu) begin
        total++;
        if (o_a !== e_a || o_b !== e_b || o_op !== op) begin
          bad++;
          $display("FAIL rand_operands[%0d] a=%h b=%h op=%h want %h/%h/%h", n, o_a, o_b, o_op, e_a, e_b, op);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_neg();
    test_full_empty();
    test_div_zero();
    test_rst_exec();
    test_reject_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/alu_opstack.md
ALU_OPSTACK -- requirements
Module: alu_opstack

Interface
REQ-001 Parameter: DEPTH, 16, operand stack entries (power of two, 4..64).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
REQ-006 cmd_type  input  2  00 push, 01 pop, 10 ALU op, 11 reserved.
REQ-007 cmd_op  input  4  ALU op code for cmd_type 10.
REQ-008 cmd_data  input  32  push value.
REQ-009 alu_a, alu_b  output  32 each  registered operands driven to the ALU.
REQ-010 alu_op  output  4  registered op code driven to the ALU.
REQ-011 alu_result  input  32  combinational ALU result.
REQ-012 top  output  32  current top-of-stack entry, 0 when empty.
REQ-013 depth  output  log2(DEPTH)+1  current entry count.
REQ-014 done  output  1  one-cycle pulse on command completion, successful or rejected.
REQ-015 err  output  1  one-cycle pulse with done when a command was rejected.

Function
REQ-016 States: IDLE, EXEC, DONE; reset state IDLE.
REQ-017 Accept at cycle T: push/pop go IDLE->DONE; legal ALU op goes IDLE->EXEC->DONE; DONE->IDLE always.
REQ-018 Push: cmd_data written above top at end of T; depth+1, done=1 in T+1.
REQ-019 Pop: top entry discarded at end of T; depth-1, done=1 in T+1.
REQ-020 Legal op codes: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 rem, 0101 neg, 1100 shl, 1101 shr, 1111 and, 1000 or, 1001 xor; all others rejected.
REQ-021 Binary op: at end of T alu_a <= entry below top, alu_b <= top, alu_op <= cmd_op; in T+1 (EXEC) alu_result sampled and written over the lower entry; depth-1; done=1 in T+2.
REQ-022 Unary op (0101): alu_a <= top, alu_b <= 0; result replaces top; depth unchanged; done in T+2.
REQ-023 alu_a, alu_b, alu_op hold their values outside EXEC.
REQ-024 Rejection cases: push at depth=DEPTH, pop at depth=0, binary op at depth<2, unary op at depth<1, illegal op code, cmd_type 11, div/rem with alu_b[15:0]=0.
REQ-025 Rejected command: no stack or depth change, goes IDLE->DONE, done=1 in T+1 (div/rem-by-zero in T+2, detected in EXEC).
REQ-026 cmd_valid while cmd_ready=0 is ignored; no queuing.
REQ-027 top combinationally reflects stack state after each registered update.

Reset
REQ-028 rst asserted at any time, including mid-EXEC: state=IDLE, depth=0, top=0, alu_a=0, alu_b=0, alu_op=0, done=0, err=0, cmd_ready=1 after release; in-flight command lost.
REQ-029 Stack storage contents need not be reset; only the pointer.

Configuration
REQ-030 Macro OPSTACK_ERR_EN: defined -> rejection detection and err as REQ-024/025.
REQ-031 Undefined -> err tied 0; depth/op-code checks still block the command silently; div/rem-by-zero not checked, ALU result written as produced.

Verification
REQ-032 Reset, push 7, push 5, op 0000 -> alu_a=7, alu_b=5 in EXEC; done at T+2; top=12, depth=1.
REQ-033 Push 20, push 3, op 0001 then op 0101 -> top=17 then top=0xFFFF_FFEE, depth=1.
REQ-034 Push DEPTH values then one more push -> done+err at T+1, depth=DEPTH, top unchanged; pop at depth 0 -> err, depth=0.
REQ-035 Push 9, push 0, op 0011 -> with OPSTACK_ERR_EN err in T+2, depth=2, top=0; without macro err=0, depth=1.
REQ-036 Push 1, push 2, op 1100, assert rst during EXEC -> depth=0, top=0, alu_a=0, no done; next push 4 -> top=4, depth=1.
REQ-037 cmd_type 11 and op 0110 -> done+err at T+1, no state change; cmd_valid held during EXEC/DONE not accepted.
